// File: rtl/delay_tap_pkg.sv
// Shared types and constants for the tapped delay element sequencer.
// Imported by delay_tap_ctrl and delay_settle_timer.
package delay_tap_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_GRANT,
        ST_STEP,
        ST_SETTLE,
        ST_ACK
    } state_e;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

    localparam logic REQ_CAL = 1'b0;
    localparam logic REQ_USR = 1'b1;

endpackage

// File: rtl/delay_settle_timer.sv
// Settle-gap down-counter: loaded on each MOVE pulse, done once it has
// counted out SETTLE cycles of the SETTLE state.
module delay_settle_timer
    import delay_tap_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    // Loading SETTLE-1 makes done coincide with the last settle cycle.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/delay_tap_ctrl.sv
// Two-requester sequencer for a LOADN/MOVE/DIRECTION tapped delay element.
// Define DLY_TAP_CLAMP_EN to clamp out-of-range targets instead of rejecting them (ERR removed).
module delay_tap_ctrl
    import delay_tap_pkg::*;
#(
    parameter int TAP_W   = 7,
    parameter int TAP_MAX = 127,
    parameter int SETTLE  = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CAL_REQ,
    input  logic [TAP_W-1:0] CAL_TAP,
    output logic             CAL_ACK,
    input  logic             USR_REQ,
    input  logic [TAP_W-1:0] USR_TAP,
    output logic             USR_ACK,
    output logic             LOADN,
    output logic             MOVE,
    output logic             DIRECTION,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             BUSY
`ifndef DLY_TAP_CLAMP_EN
    ,
    output logic             ERR
`endif
);

    localparam logic [TAP_W:0] MAX_EXT = (TAP_W + 1)'(TAP_MAX);

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic [TAP_W-1:0] tgt_q, tgt_d;
    logic [TAP_W-1:0] cur_q, cur_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    logic             req_any;
    logic [TAP_W-1:0] req_tap;
    logic [TAP_W-1:0] req_tgt;
    logic             req_oor;

    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_done;

`ifdef DLY_TAP_CLAMP_EN
    function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] t);
        if ({1'b0, t} > MAX_EXT) begin
            return MAX_EXT[TAP_W-1:0];
        end
        return t;
    endfunction
`else
    function automatic logic tap_out_of_range(input logic [TAP_W-1:0] t);
        return ({1'b0, t} > MAX_EXT);
    endfunction
`endif

    // Fixed-priority arbiter: CAL wins whenever it is asserted in IDLE.
    assign req_any = CAL_REQ | USR_REQ;
    assign req_tap = CAL_REQ ? CAL_TAP : USR_TAP;

`ifdef DLY_TAP_CLAMP_EN
    assign req_tgt = clamp_tap(req_tap);
    assign req_oor = 1'b0;
`else
    assign req_tgt = req_tap;
    assign req_oor = tap_out_of_range(req_tap);
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        tgt_d    = tgt_q;
        cur_d    = cur_q;
        dir_d    = dir_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                cur_d   = '0;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req_any) begin
                    grant_d = CAL_REQ ? REQ_CAL : REQ_USR;
                    tgt_d   = req_tgt;
                    err_d   = req_oor;
                    // Direction is settled during GRANT so it leads the first MOVE.
                    if (!req_oor) begin
                        dir_d = (req_tgt < cur_q) ? DIR_DEC : DIR_INC;
                    end
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (err_q || (tgt_q == cur_q)) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                tmr_load = 1'b1;
                cur_d    = (dir_q == DIR_DEC) ? (cur_q - TAP_W'(1)) : (cur_q + TAP_W'(1));
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    state_d = (cur_q != tgt_q) ? ST_STEP : ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= ST_INIT;
            grant_q <= REQ_CAL;
            cur_q   <= '0;
            dir_q   <= DIR_INC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cur_q   <= cur_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    // Target is only meaningful after a grant, so it carries no reset.
    always_ff @(posedge CLK) begin
        tgt_q <= tgt_d;
    end

    delay_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .done_o (tmr_done)
    );

    assign LOADN     = (state_q != ST_INIT);
    assign MOVE      = (state_q == ST_STEP);
    assign DIRECTION = dir_q;
    assign CUR_TAP   = cur_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign CAL_ACK   = (state_q == ST_ACK) && (grant_q == REQ_CAL);
    assign USR_ACK   = (state_q == ST_ACK) && (grant_q == REQ_USR);
`ifndef DLY_TAP_CLAMP_EN
    assign ERR       = (state_q == ST_ACK) && err_q;
`endif

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Scoreboard bench for delay_tap_ctrl (TAP_MAX=100, SETTLE=4); honours DLY_TAP_CLAMP_EN.
module tb_delay_tap_ctrl;

    localparam int TAP_W   = 7;
    localparam int TAP_MAX = 100;
    localparam int SETTLE  = 4;
    localparam int GAP     = SETTLE + 1;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cal_req = 1'b0;
    logic             usr_req = 1'b0;
    logic [TAP_W-1:0] cal_tap = '0;
    logic [TAP_W-1:0] usr_tap = '0;
    logic             cal_ack, usr_ack, loadn, move, direction, busy, err;
    logic [TAP_W-1:0] cur_tap;

    always #5 clk = ~clk;

    delay_tap_ctrl #(
        .TAP_W   (TAP_W),
        .TAP_MAX (TAP_MAX),
        .SETTLE  (SETTLE)
    ) dut (
        .CLK       (clk),
        .RSTN      (rstn),
        .CAL_REQ   (cal_req),
        .CAL_TAP   (cal_tap),
        .CAL_ACK   (cal_ack),
        .USR_REQ   (usr_req),
        .USR_TAP   (usr_tap),
        .USR_ACK   (usr_ack),
        .LOADN     (loadn),
        .MOVE      (move),
        .DIRECTION (direction),
        .CUR_TAP   (cur_tap),
        .BUSY      (busy)
`ifndef DLY_TAP_CLAMP_EN
        ,
        .ERR       (err)
`endif
    );

`ifdef DLY_TAP_CLAMP_EN
    assign err = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int model_tap = 0;

    typedef struct {
        bit is_cal;
        int tap;
        bit err;
        int lat;
        int moves;
        bit dir;
    } exp_t;

    typedef struct {
        bit got;
        bit cal;
        bit usr;
        bit err;
        int tap;
        int cyc;
        int moves;
        bit dir;
        bit dir_stable;
        int min_gap;
        int max_gap;
    } obs_t;

    exp_t sb[$];

    // Observes the DUT until an ACK pulse; drops the acknowledged REQ on that cycle.
    task automatic wait_ack(input int budget, output obs_t o);
        int   last_move;
        logic prev_dir;
        o.got = 0; o.cal = 0; o.usr = 0; o.err = 0; o.tap = 0; o.cyc = 0;
        o.moves = 0; o.dir = 0; o.dir_stable = 1; o.min_gap = 1000000; o.max_gap = 0;
        last_move = -1;
        prev_dir  = direction;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (move) begin
                o.moves++;
                o.dir = direction;
                if (direction !== prev_dir) o.dir_stable = 0;
                if (last_move >= 0) begin
                    if (c - last_move < o.min_gap) o.min_gap = c - last_move;
                    if (c - last_move > o.max_gap) o.max_gap = c - last_move;
                end
                last_move = c;
            end
            prev_dir = direction;
            if (cal_ack || usr_ack) begin
                o.got = 1; o.cal = cal_ack; o.usr = usr_ack; o.err = err;
                o.tap = int'(cur_tap); o.cyc = c;
                if (cal_ack) cal_req = 1'b0;
                if (usr_ack) usr_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({loadn, move, direction, cur_tap, cal_ack, usr_ack, busy, err} !== {3'b000, 7'd0, 4'b0010}) begin
            n_fail++;
            $display("FAIL reset_values: got loadn=%b move=%b dir=%b tap=%0d cack=%b uack=%b busy=%b err=%b",
                     loadn, move, direction, cur_tap, cal_ack, usr_ack, busy, err);
        end
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({loadn, busy} !== 2'b01) begin
            n_fail++; $display("FAIL init_cycle: loadn=%b busy=%b, want loadn=0 busy=1", loadn, busy);
        end
        @(negedge clk);
        n_checks++;
        if ({loadn, busy, cur_tap} !== {2'b10, 7'd0}) begin
            n_fail++; $display("FAIL idle_after_init: loadn=%b busy=%b tap=%0d, want 1 0 0", loadn, busy, cur_tap);
        end
        model_tap = 0;
    endtask

    task automatic test_usr_move();
        obs_t o; exp_t e;
        usr_tap = 7'd3; usr_req = 1'b1;
        sb.push_back('{is_cal: 0, tap: 3, err: 0, lat: 2 + 3 * GAP, moves: 3, dir: 0});
        wait_ack(300, o);
        e = sb.pop_front();
        n_checks++; if (!o.got) begin n_fail++; $display("FAIL usr3_ack: no ACK within budget"); end
        n_checks++; if ({o.cal, o.usr} !== 2'b01) begin n_fail++; $display("FAIL usr3_owner: cal=%b usr=%b, want usr", o.cal, o.usr); end
        n_checks++; if (o.tap != e.tap) begin n_fail++; $display("FAIL usr3_tap: got %0d want %0d", o.tap, e.tap); end
        n_checks++; if (o.cyc != e.lat) begin n_fail++; $display("FAIL usr3_latency: got %0d want %0d", o.cyc, e.lat); end
        n_checks++; if (o.moves != e.moves) begin n_fail++; $display("FAIL usr3_moves: got %0d want %0d", o.moves, e.moves); end
        n_checks++; if (o.dir != e.dir || !o.dir_stable) begin n_fail++; $display("FAIL usr3_dir: got %b stable=%b want %b", o.dir, o.dir_stable, e.dir); end
        n_checks++; if (o.min_gap != GAP || o.max_gap != GAP) begin n_fail++; $display("FAIL usr3_gap: min %0d max %0d want %0d", o.min_gap, o.max_gap, GAP); end
        @(negedge clk);
        n_checks++; if ({busy, cal_ack, usr_ack} !== 3'b000) begin n_fail++; $display("FAIL usr3_ack_pulse: busy=%b cack=%b uack=%b want 000", busy, cal_ack, usr_ack); end
        model_tap = e.tap;
    endtask

    task automatic test_tie();
        obs_t o; exp_t e;
        cal_tap = 7'd1; usr_tap = 7'd5; cal_req = 1'b1; usr_req = 1'b1;
        sb.push_back('{is_cal: 1, tap: 1, err: 0, lat: 2 + 2 * GAP, moves: 2, dir: 1});
        sb.push_back('{is_cal: 0, tap: 5, err: 0, lat: 3 + 4 * GAP, moves: 4, dir: 0});
        wait_ack(300, o);
        e = sb.pop_front();
        n_checks++; if ({o.got, o.cal, o.usr} !== 3'b110) begin n_fail++; $display("FAIL tie_cal_first: got=%b cal=%b usr=%b want 110", o.got, o.cal, o.usr); end
        n_checks++; if (o.tap != e.tap) begin n_fail++; $display("FAIL tie_cal_tap: got %0d want %0d", o.tap, e.tap); end
        n_checks++; if (o.cyc != e.lat) begin n_fail++; $display("FAIL tie_cal_latency: got %0d want %0d", o.cyc, e.lat); end
        n_checks++; if (o.dir != e.dir) begin n_fail++; $display("FAIL tie_cal_dir: got %b want %b", o.dir, e.dir); end
        wait_ack(300, o);
        e = sb.pop_front();
        n_checks++; if ({o.got, o.cal, o.usr} !== 3'b101) begin n_fail++; $display("FAIL tie_usr_second: got=%b cal=%b usr=%b want 101", o.got, o.cal, o.usr); end
        n_checks++; if (o.tap != e.tap) begin n_fail++; $display("FAIL tie_usr_tap: got %0d want %0d", o.tap, e.tap); end
        n_checks++; if (o.moves != e.moves) begin n_fail++; $display("FAIL tie_usr_moves: got %0d want %0d", o.moves, e.moves); end
        n_checks++; if (o.cyc != e.lat) begin n_fail++; $display("FAIL tie_usr_latency: got %0d want %0d", o.cyc, e.lat); end
        @(negedge clk);
        model_tap = e.tap;
    endtask

    task automatic test_same_tap();
        obs_t o; exp_t e;
        usr_tap = 7'(model_tap); usr_req = 1'b1;
        sb.push_back('{is_cal: 0, tap: model_tap, err: 0, lat: 2, moves: 0, dir: 0});
        wait_ack(50, o);
        e = sb.pop_front();
        n_checks++; if ({o.got, o.usr} !== 2'b11) begin n_fail++; $display("FAIL same_ack: got=%b usr=%b want 11", o.got, o.usr); end
        n_checks++; if (o.cyc != e.lat) begin n_fail++; $display("FAIL same_latency: got %0d want %0d", o.cyc, e.lat); end
        n_checks++; if (o.moves != e.moves || o.tap != e.tap) begin n_fail++; $display("FAIL same_nomove: moves %0d tap %0d want %0d %0d", o.moves, o.tap, e.moves, e.tap); end
        @(negedge clk);
    endtask

    task automatic test_decrement();
        obs_t o; exp_t e;
        cal_tap = 7'd2; cal_req = 1'b1;
        sb.push_back('{is_cal: 1, tap: 2, err: 0, lat: 2 + (model_tap - 2) * GAP, moves: model_tap - 2, dir: 1});
        wait_ack(300, o);
        e = sb.pop_front();
        n_checks++; if ({o.got, o.cal} !== 2'b11) begin n_fail++; $display("FAIL dec_ack: got=%b cal=%b want 11", o.got, o.cal); end
        n_checks++; if (o.tap != e.tap) begin n_fail++; $display("FAIL dec_tap: got %0d want %0d", o.tap, e.tap); end
        n_checks++; if (o.moves != e.moves) begin n_fail++; $display("FAIL dec_moves: got %0d want %0d", o.moves, e.moves); end
        n_checks++; if (o.dir != e.dir || !o.dir_stable) begin n_fail++; $display("FAIL dec_dir: got %b stable=%b want %b", o.dir, o.dir_stable, e.dir); end
        n_checks++; if (o.cyc != e.lat) begin n_fail++; $display("FAIL dec_latency: got %0d want %0d", o.cyc, e.lat); end
        @(negedge clk);
        model_tap = e.tap;
    endtask

    task automatic test_out_of_range();
        obs_t o; exp_t e;
        usr_tap = 7'd120; usr_req = 1'b1;
`ifdef DLY_TAP_CLAMP_EN
        sb.push_back('{is_cal: 0, tap: TAP_MAX, err: 0, lat: 2 + (TAP_MAX - model_tap) * GAP, moves: TAP_MAX - model_tap, dir: 0});
`else
        sb.push_back('{is_cal: 0, tap: model_tap, err: 1, lat: 2, moves: 0, dir: 0});
`endif
        wait_ack(1000, o);
        e = sb.pop_front();
        n_checks++; if ({o.got, o.usr} !== 2'b11) begin n_fail++; $display("FAIL range_ack: got=%b usr=%b want 11", o.got, o.usr); end
        n_checks++; if (o.tap != e.tap) begin n_fail++; $display("FAIL range_tap: got %0d want %0d", o.tap, e.tap); end
        n_checks++; if (o.moves != e.moves) begin n_fail++; $display("FAIL range_moves: got %0d want %0d", o.moves, e.moves); end
        n_checks++; if (o.cyc != e.lat) begin n_fail++; $display("FAIL range_latency: got %0d want %0d", o.cyc, e.lat); end
`ifndef DLY_TAP_CLAMP_EN
        n_checks++; if (o.err != e.err) begin n_fail++; $display("FAIL range_err: got %b want %b", o.err, e.err); end
`endif
        @(negedge clk);
        n_checks++; if ({err, usr_ack, busy} !== 3'b000) begin n_fail++; $display("FAIL range_pulse: err=%b uack=%b busy=%b want 000", err, usr_ack, busy); end
        model_tap = e.tap;
    endtask

    task automatic test_reset_abort();
        int  tgt;
        int  moves;
        bit  acked;
        tgt = (model_tap <= TAP_MAX - 6) ? model_tap + 6 : model_tap - 6;
        usr_tap = 7'(tgt); usr_req = 1'b1;
        moves = 0; acked = 0;
        for (int c = 0; c < 100 && moves < 2; c++) begin
            @(negedge clk);
            if (move) moves++;
            if (cal_ack || usr_ack) acked = 1;
        end
        n_checks++; if (moves != 2 || acked) begin n_fail++; $display("FAIL abort_setup: moves %0d acked %b want 2 0", moves, acked); end
        rstn = 1'b0; usr_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (cal_ack || usr_ack) acked = 1;
        end
        n_checks++;
        if ({loadn, move, direction, cur_tap, cal_ack, usr_ack, busy, err} !== {3'b000, 7'd0, 4'b0010}) begin
            n_fail++;
            $display("FAIL abort_reset_values: loadn=%b move=%b dir=%b tap=%0d cack=%b uack=%b busy=%b err=%b",
                     loadn, move, direction, cur_tap, cal_ack, usr_ack, busy, err);
        end
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        n_checks++; if (loadn !== 1'b0) begin n_fail++; $display("FAIL abort_init_loadn: got %b want 0", loadn); end
        @(negedge clk);
        if (cal_ack || usr_ack) acked = 1;
        n_checks++; if ({loadn, busy, cur_tap} !== {2'b10, 7'd0}) begin n_fail++; $display("FAIL abort_idle: loadn=%b busy=%b tap=%0d want 1 0 0", loadn, busy, cur_tap); end
        n_checks++; if (acked) begin n_fail++; $display("FAIL abort_no_ack: got ack=1 want 0"); end
        model_tap = 0;
    endtask

    task automatic test_after_abort();
        obs_t o; exp_t e;
        usr_tap = 7'd2; usr_req = 1'b1;
        sb.push_back('{is_cal: 0, tap: 2, err: 0, lat: 2 + 2 * GAP, moves: 2, dir: 0});
        wait_ack(200, o);
        e = sb.pop_front();
        n_checks++; if ({o.got, o.usr} !== 2'b11) begin n_fail++; $display("FAIL post_ack: got=%b usr=%b want 11", o.got, o.usr); end
        n_checks++; if (o.tap != e.tap || o.moves != e.moves) begin n_fail++; $display("FAIL post_tap: tap %0d moves %0d want %0d %0d", o.tap, o.moves, e.tap, e.moves); end
        n_checks++; if (o.cyc != e.lat) begin n_fail++; $display("FAIL post_latency: got %0d want %0d", o.cyc, e.lat); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_usr_move();
        test_tie();
        test_same_tap();
        test_decrement();
        test_out_of_range();
        test_reset_abort();
        test_after_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
